atm_keypad_frontend: RTL

- Upstream stage of the ATM controller.
- Turns raw scanned keypad codes into the controller's strobed inputs:
  - PIN digits: DIGITO/DIGITO_STB
  - transaction type: TIPO_TRANS/TIPO_STB
  - BCD-entered amount, converted to binary: MONTO/MONTO_STB
- Debounces keys, tracks the session phase from card presence and controller feedback, and drops keys that are invalid for the current phase.

---
 rtl/atm_pkg.sv | 30 +++
 rtl/atm_keypad_frontend_if.sv | 28 ++
 rtl/atm_key_debounce.sv | 53 +++++
 rtl/atm_keypad_frontend.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared key codes, phase encoding and arithmetic helpers for the ATM keypad front end.
package atm_pkg;

    localparam logic [3:0] K_DEP    = 4'hA;
    localparam logic [3:0] K_RET    = 4'hB;
    localparam logic [3:0] K_BORRAR = 4'hC;
    localparam logic [3:0] K_ENTER  = 4'hD;

    localparam logic TIPO_DEP = 1'b0;
    localparam logic TIPO_RET = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PIN   = 3'd1,
        TIPO  = 3'd2,
        MONTO = 3'd3,
        FIN   = 3'd4,
        BLOQ  = 3'd5
    } phase_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    // acc*10 + d without a multiplier
    function automatic logic [31:0] times10_plus(input logic [31:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {28'd0, d};
    endfunction

endpackage

// File: rtl/atm_keypad_frontend_if.sv
// Keypad/controller signal bundle; master drives the keypad and controller feedback, slave is the front end.
interface atm_keypad_frontend_if;

    logic [3:0]  TECLA;
    logic        TECLA_VALIDA;
    logic        TARJETA_RECIBIDA;
    logic        PIN_INCORRECTO;
    logic        Bloqueo;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic        TIPO_TRANS;
    logic        TIPO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [31:0] ACUM;
    logic [3:0]  NUM_DIG;

    modport master (
        output TECLA, TECLA_VALIDA, TARJETA_RECIBIDA, PIN_INCORRECTO, Bloqueo,
        input  DIGITO, DIGITO_STB, TIPO_TRANS, TIPO_STB, MONTO, MONTO_STB, ACUM, NUM_DIG
    );

    modport slave (
        input  TECLA, TECLA_VALIDA, TARJETA_RECIBIDA, PIN_INCORRECTO, Bloqueo,
        output DIGITO, DIGITO_STB, TIPO_TRANS, TIPO_STB, MONTO, MONTO_STB, ACUM, NUM_DIG
    );

endinterface

// File: rtl/atm_key_debounce.sv
// One registered event per key press once TECLA has been held stable for DEB_CYC cycles (DEB_CYC >= 2).
module atm_key_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] TECLA,
    input  logic       TECLA_VALIDA,
    output logic       key_evt,
    output logic [3:0] key_code
);

    localparam int            CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] CNT_TC   = CW'(1);

    logic [CW-1:0] cnt;
    logic [3:0]    code_q;
    logic          armed;
    logic          trk;

    // armed stays low out of reset so a key already held is ignored until released
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt      <= '0;
            code_q   <= '0;
            armed    <= 1'b0;
            trk      <= 1'b0;
            key_evt  <= 1'b0;
            key_code <= '0;
        end else begin
            key_evt <= 1'b0;
            if (!TECLA_VALIDA) begin
                armed <= 1'b1;
                trk   <= 1'b0;
            end else if (armed) begin
                if (!trk || (TECLA != code_q)) begin
                    trk    <= 1'b1;
                    code_q <= TECLA;
                    cnt    <= CNT_LOAD;
                end else if (cnt == CNT_TC) begin
                    key_evt  <= 1'b1;
                    key_code <= code_q;
                    armed    <= 1'b0;
                    trk      <= 1'b0;
                end else begin
                    cnt <= cnt - CNT_TC;
                end
            end
        end
    end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Session-phase FSM and amount accumulator turning debounced keys into strobed controller inputs.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int DEB_CYC = 4,
    parameter int MAX_DIG = 9
) (
    input logic                  Clk,
    input logic                  Reset,
    atm_keypad_frontend_if.slave bus
);

    phase_t      phase, phase_n;
    logic        card_q;
    logic [1:0]  pin_cnt, pin_cnt_n;
    logic [31:0] acum, acum_n;
    logic [3:0]  num, num_n;
    logic [3:0]  digito, digito_n;
    logic        tipo, tipo_n;
    logic [31:0] monto, monto_n;
    logic        dstb, dstb_n;
    logic        tstb, tstb_n;
    logic        mstb, mstb_n;

    logic        key_evt;
    logic [3:0]  key_code;
    logic        card_rise;
    logic        card_gone;
    logic        evt_dig;

    atm_key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .Clk         (Clk),
        .Reset       (Reset),
        .TECLA       (bus.TECLA),
        .TECLA_VALIDA(bus.TECLA_VALIDA),
        .key_evt     (key_evt),
        .key_code    (key_code)
    );

    assign card_rise = bus.TARJETA_RECIBIDA && !card_q;
    assign card_gone = !bus.TARJETA_RECIBIDA;
    assign evt_dig   = key_evt && is_digit(key_code);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            phase   <= IDLE;
            card_q  <= 1'b0;
            pin_cnt <= '0;
            acum    <= '0;
            num     <= '0;
            digito  <= '0;
            tipo    <= 1'b0;
            monto   <= '0;
            dstb    <= 1'b0;
            tstb    <= 1'b0;
            mstb    <= 1'b0;
        end else begin
            phase   <= phase_n;
            card_q  <= bus.TARJETA_RECIBIDA;
            pin_cnt <= pin_cnt_n;
            acum    <= acum_n;
            num     <= num_n;
            digito  <= digito_n;
            tipo    <= tipo_n;
            monto   <= monto_n;
            dstb    <= dstb_n;
            tstb    <= tstb_n;
            mstb    <= mstb_n;
        end
    end

    // Priority: Bloqueo, card removal, PIN_INCORRECTO, key event
    always_comb begin
        phase_n = phase;
        if (bus.Bloqueo) begin
            phase_n = BLOQ;
        end else begin
            case (phase)
                IDLE: if (card_rise) phase_n = PIN;
                BLOQ: phase_n = BLOQ;
                default: begin
                    if (card_gone) begin
                        phase_n = IDLE;
                    end else begin
                        case (phase)
                            PIN:  if (evt_dig && (pin_cnt == 2'd3)) phase_n = TIPO;
                            TIPO: begin
                                if (bus.PIN_INCORRECTO)
                                    phase_n = PIN;
                                else if (key_evt && ((key_code == K_DEP) || (key_code == K_RET)))
                                    phase_n = MONTO;
                            end
                            MONTO: if (key_evt && (key_code == K_ENTER) && (num != 4'd0)) phase_n = FIN;
                            default: phase_n = phase;
                        endcase
                    end
                end
            endcase
        end
    end

    always_comb begin
        pin_cnt_n = pin_cnt;
        acum_n    = acum;
        num_n     = num;
        digito_n  = digito;
        tipo_n    = tipo;
        monto_n   = monto;
        dstb_n    = 1'b0;
        tstb_n    = 1'b0;
        mstb_n    = 1'b0;
        if (!bus.Bloqueo) begin
            case (phase)
                IDLE: if (card_rise) pin_cnt_n = 2'd0;
                PIN, TIPO, MONTO, FIN: begin
                    if (card_gone) begin
                        acum_n = '0;
                        num_n  = '0;
                    end else begin
                        case (phase)
                            PIN: begin
                                if (evt_dig) begin
                                    digito_n  = key_code;
                                    dstb_n    = 1'b1;
                                    pin_cnt_n = pin_cnt + 2'd1;
                                end
                            end
                            TIPO: begin
                                if (bus.PIN_INCORRECTO) begin
                                    pin_cnt_n = 2'd0;
                                end else if (key_evt && (key_code == K_DEP)) begin
                                    tipo_n = TIPO_DEP;
                                    tstb_n = 1'b1;
                                end else if (key_evt && (key_code == K_RET)) begin
                                    tipo_n = TIPO_RET;
                                    tstb_n = 1'b1;
                                end
                            end
                            MONTO: begin
                                if (evt_dig && (num < 4'(MAX_DIG))) begin
                                    acum_n = times10_plus(acum, key_code);
                                    num_n  = num + 4'd1;
                                end else if (key_evt && (key_code == K_BORRAR)) begin
                                    acum_n = '0;
                                    num_n  = '0;
                                end else if (key_evt && (key_code == K_ENTER) && (num != 4'd0)) begin
                                    monto_n = acum;
                                    mstb_n  = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.DIGITO     = digito;
    assign bus.DIGITO_STB = dstb;
    assign bus.TIPO_TRANS = tipo;
    assign bus.TIPO_STB   = tstb;
    assign bus.MONTO      = monto;
    assign bus.MONTO_STB  = mstb;
    assign bus.ACUM       = acum;
    assign bus.NUM_DIG    = num;

endmodule
